// File: rtl/alu_seq.sv
// Registered W-bit ALU with valid/ready handshakes on both sides.
// Single-cycle ops finish on accept; MUL and non-zero shifts iterate one step per BUSY cycle.
module alu_seq #(
    parameter int W      = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         flag_zero,
    output logic         flag_carry
);

    localparam int LW = $clog2(W);
    localparam int CW = LW + 1;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_CMP   = 4'd2;
    localparam logic [3:0] OP_MUL   = 4'd3;
    localparam logic [3:0] OP_BUF   = 4'd4;
    localparam logic [3:0] OP_NOT   = 4'd5;
    localparam logic [3:0] OP_AND   = 4'd6;
    localparam logic [3:0] OP_NAND  = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_NOR   = 4'd9;
    localparam logic [3:0] OP_XOR   = 4'd10;
    localparam logic [3:0] OP_XNOR  = 4'd11;
    localparam logic [3:0] OP_SHL   = 4'd12;
    localparam logic [3:0] OP_SHR   = 4'd13;
    localparam logic [3:0] OP_DEC   = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [W-1:0]     a_q, a_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [W-1:0]     res_q, res_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic [LW-1:0]    shamt;
    logic [W:0]       single;
    logic [W:0]       mul_sum;
    logic [W-1:0]     step_val;
    logic             step_c;

    // Returns {carry, result} for every op that completes on accept.
    function automatic logic [W:0] alu_single(input logic [3:0] f_op,
                                              input logic [W-1:0] x,
                                              input logic [W-1:0] y);
        logic [W:0]   r;
        logic [W+1:0] cmp;
        r   = '0;
        cmp = '0;
        case (f_op)
            OP_ADD:   r = {1'b0, x} + {1'b0, y};
            OP_SUB:   r = {1'b0, x} - {1'b0, y};
            OP_CMP: begin
                cmp[2] = (x > y);
                cmp[1] = (x == y);
                cmp[0] = (x < y);
                r      = {1'b0, cmp[W-1:0]};
            end
            OP_MUL:   r = '0;
            OP_BUF:   r = {1'b0, x};
            OP_NOT:   r = {1'b0, ~x};
            OP_AND:   r = {1'b0, x & y};
            OP_NAND:  r = {1'b0, ~(x & y)};
            OP_OR:    r = {1'b0, x | y};
            OP_NOR:   r = {1'b0, ~(x | y)};
            OP_XOR:   r = {1'b0, x ^ y};
            OP_XNOR:  r = {1'b0, ~(x ^ y)};
            OP_SHL:   r = {1'b0, x};
            OP_SHR:   r = {1'b0, x};
            OP_DEC:   r = {1'b0, x} - (W+1)'(1);
            OP_PASSB: r = {1'b0, y};
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign out_valid = (state_q == S_DONE);
    assign result    = res_q;
    assign flag_zero = zero_q;
    assign flag_carry = carry_q;

    assign accept  = in_valid && in_ready;
    assign shamt   = b[LW-1:0];
    assign single  = alu_single(op, a, b);
    // Multiplier sits in the low half of acc and is consumed LSB first.
    assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        acc_d    = acc_q;
        res_d    = res_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        step_val = '0;
        step_c   = 1'b0;

        case (state_q)
            S_BUSY: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d    = {mul_sum, acc_q[W-1:1]};
                    step_val = acc_d[W-1:0];
                    step_c   = |acc_d[2*W-1:W];
                end else if (op_q == OP_SHL) begin
                    a_d      = a_q << 1;
                    step_val = a_d;
                    step_c   = a_q[W-1];
                end else begin
                    a_d      = a_q >> 1;
                    step_val = a_d;
                    step_c   = a_q[0];
                end
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    res_d   = step_val;
                    carry_d = step_c;
                    zero_d  = (step_val == '0);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            op_d  = op;
            a_d   = a;
            acc_d = {{W{1'b0}}, b};
            if (MUL_EN && (op == OP_MUL)) begin
                state_d = S_BUSY;
                cnt_d   = CW'(W);
            end else if (((op == OP_SHL) || (op == OP_SHR)) && (shamt != '0)) begin
                state_d = S_BUSY;
                cnt_d   = {1'b0, shamt};
            end else begin
                state_d = S_DONE;
                res_d   = single[W-1:0];
                carry_d = single[W];
                zero_d  = (single[W-1:0] == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
        end
    end

    // Operand/working registers are only meaningful after an accept, so they carry no reset.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        a_q   <= a_d;
        acc_q <= acc_d;
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: arithmetic reference model, per-cycle compare,
// directed literal cases and randomized handshake traffic.
module tb_alu_seq;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [3:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_carry;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Model state: cycles still to wait, whether a result is presented, and its value.
    int pend  = 0;
    bit have  = 1'b0;
    int m_res = 0;
    int m_c   = 0;

    always #5 clk = ~clk;

    alu_seq #(.W(W), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_carry(flag_carry)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void ref_op(input int f, input int x, input int y,
                                   output int r, output int c, output int lat);
        int n;
        n = y % W;
        r = 0; c = 0; lat = 1;
        case (f)
            0:  begin r = (x + y) % M; c = (x + y >= M) ? 1 : 0; end
            1:  begin r = (x - y + M) % M; c = (x < y) ? 1 : 0; end
            2:  r = (x > y) ? 4 : ((x == y) ? 2 : 1);
            3:  begin r = (x * y) % M; c = ((x * y) / M != 0) ? 1 : 0; lat = W + 1; end
            4:  r = x;
            5:  r = M - 1 - x;
            6:  r = x & y;
            7:  r = M - 1 - (x & y);
            8:  r = x | y;
            9:  r = M - 1 - (x | y);
            10: r = x ^ y;
            11: r = M - 1 - (x ^ y);
            12: begin r = (x << n) % M; c = (n != 0) ? ((x >> (W - n)) & 1) : 0; lat = n + 1; end
            13: begin r = x >> n; c = (n != 0) ? ((x >> (n - 1)) & 1) : 0; lat = n + 1; end
            14: begin r = (x + M - 1) % M; c = (x == 0) ? 1 : 0; end
            default: r = y;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int r, c, l, np;
        bit nh, rdy;
        if (!rst_n) begin
            pend <= 0;
            have <= 1'b0;
        end else begin
            np  = pend;
            nh  = have;
            rdy = (pend == 0) && (!have || out_ready);
            if (nh && out_ready) nh = 1'b0;
            if (np > 0) begin
                np--;
                if (np == 0) nh = 1'b1;
            end
            if (in_valid && rdy) begin
                ref_op(int'(op), int'(a), int'(b), r, c, l);
                m_res <= r;
                m_c   <= c;
                np = l - 1;
                if (np == 0) nh = 1'b1;
            end
            pend <= np;
            have <= nh;
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("in_ready", in_ready, 32'((pend == 0) && (!have || out_ready)));
            check("out_valid", out_valid, 32'(have));
            if (have) begin
                check("result", result, m_res);
                check("carry", flag_carry, m_c);
                check("zero", flag_zero, 32'(m_res == 0));
            end
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic run_op(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic rdy_seen);
        tick;
        op = o; a = x; b = y; in_valid = 1'b1;
        rdy_seen = 1'b0;
        tick;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            tick;
            lat++;
        end
    endtask

    function automatic logic [W-1:0] pick;
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int   lat, r, c, l;
        logic rs;

        // Model pinned to hand-computed values.
        ref_op(0, 'hF0, 'h20, r, c, l);
        check("model_add", {r[15:0], c[7:0], l[7:0]}, {16'h10, 8'd1, 8'd1});
        ref_op(3, 'h10, 'h10, r, c, l);
        check("model_mul", {r[15:0], c[7:0], l[7:0]}, {16'h00, 8'd1, 8'd9});
        ref_op(12, 'h81, 'h03, r, c, l);
        check("model_shl", {r[15:0], c[7:0], l[7:0]}, {16'h08, 8'd0, 8'd4});
        ref_op(13, 'h81, 'h01, r, c, l);
        check("model_shr", {r[15:0], c[7:0], l[7:0]}, {16'h40, 8'd1, 8'd2});
        ref_op(14, 0, 0, r, c, l);
        check("model_dec", {r[15:0], c[7:0], l[7:0]}, {16'hFF, 8'd1, 8'd1});

        #1 rst_n = 1'b0;
        repeat (2) tick;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_flags", {flag_zero, flag_carry}, 0);
        out_ready = 1'b1;
        rst_n = 1'b1;
        chk_en = 1'b1;

        run_op(4'd0, 8'hF0, 8'h20, lat, rs);
        check("add_lat", lat, 1);
        check("add_res", {result, flag_carry, flag_zero}, {8'h10, 1'b1, 1'b0});

        run_op(4'd3, 8'h10, 8'h10, lat, rs);
        check("mul_lat", lat, 9);
        check("mul_busy_ready", rs, 0);
        check("mul_res", {result, flag_carry, flag_zero}, {8'h00, 1'b1, 1'b1});

        run_op(4'd12, 8'h81, 8'h03, lat, rs);
        check("shl_lat", lat, 4);
        check("shl_res", {result, flag_carry}, {8'h08, 1'b0});
        run_op(4'd13, 8'h81, 8'h01, lat, rs);
        check("shr_lat", lat, 2);
        check("shr_res", {result, flag_carry}, {8'h40, 1'b1});
        run_op(4'd12, 8'h81, 8'h08, lat, rs);
        check("shl0_lat", lat, 1);
        check("shl0_res", {result, flag_carry}, {8'h81, 1'b0});

        run_op(4'd2, 8'd5, 8'd9, lat, rs);
        check("cmp_lt", result, 8'h01);
        run_op(4'd2, 8'd9, 8'd9, lat, rs);
        check("cmp_eq", result, 8'h02);
        run_op(4'd14, 8'h00, 8'h00, lat, rs);
        check("dec_wrap", {result, flag_carry}, {8'hFF, 1'b1});

        // Output stall: result must hold and new requests must be refused.
        tick;
        out_ready = 1'b0;
        run_op(4'd10, 8'hAA, 8'hFF, lat, rs);
        for (int i = 0; i < 5; i++) begin
            op = 4'd0; a = 8'd1; b = 8'd2; in_valid = 1'b1;
            #1;
            check("stall_res", result, 8'h55);
            check("stall_ready", in_ready, 0);
            tick;
        end
        a = 8'd3; b = 8'd4; out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        check("stall_release", {out_valid, result}, {1'b1, 8'h07});

        for (int i = 0; i < 6; i++) begin
            op = 4'd0; a = W'(i); b = 8'd10; in_valid = 1'b1;
            tick;
            check("stream", {out_valid, result}, {1'b1, W'(i + 10)});
        end

        // Reset in the middle of a multiply.
        op = 4'd3; a = 8'h10; b = 8'h10; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_result", {result, flag_zero, flag_carry}, 0);
        tick;
        rst_n = 1'b1;
        run_op(4'd0, 8'd1, 8'd1, lat, rs);
        check("post_rst_lat", lat, 1);
        check("post_rst_res", result, 8'h02);

        for (int i = 0; i < 3000; i++) begin
            tick;
            in_valid  = ($urandom_range(0, 99) < 70);
            op        = 4'($urandom);
            a         = pick();
            b         = pick();
            out_ready = ($urandom_range(0, 99) < 60);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (12) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
